// File: rtl/icache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : icache_mem_arbiter
// Brief   : Round-robin sharing of one instruction-memory port between several
//           instruction caches, with in-order routing of memory responses.
// Revision: 1.0
// ============================================================================
module icache_mem_arbiter #(
    parameter int NUM_REQUESTERS       = 4,
    parameter int CACHELINE_ADDR_WIDTH = 6,
    parameter int CACHELINE_IDX_BITS   = 2,
    parameter int ENC_INST_WIDTH       = 32,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic [NUM_REQUESTERS-1:0]                       req_valid_i,
    output logic [NUM_REQUESTERS-1:0]                       req_ready_o,
    input  logic [NUM_REQUESTERS*CACHELINE_ADDR_WIDTH-1:0]  req_addr_i,
    output logic [NUM_REQUESTERS-1:0]                       rsp_valid_o,
    output logic [(ENC_INST_WIDTH<<CACHELINE_IDX_BITS)-1:0] rsp_data_o,
    output logic                                            mem_req_o,
    input  logic                                            mem_ready_i,
    output logic [CACHELINE_ADDR_WIDTH-1:0]                 mem_addr_o,
    input  logic                                            mem_valid_i,
    input  logic [(ENC_INST_WIDTH<<CACHELINE_IDX_BITS)-1:0] mem_data_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]            outstanding_o
);

    localparam int c_ID_W  = $clog2(NUM_REQUESTERS);
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [c_ID_W-1:0]  r_rr_ptr;
    logic               r_locked;
    logic [c_ID_W-1:0]  r_lock_id;
    logic [c_ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_ID_W-1:0]  w_rr_id;
    logic [c_ID_W-1:0]  w_winner;
    logic [c_ID_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_hs;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] f_inc_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full        = (r_count == c_CNT_W'(MAX_OUTSTANDING));
    assign w_empty       = (r_count == '0);
    assign w_head        = r_fifo[r_rd_ptr];
    assign outstanding_o = r_count;
    assign rsp_data_o    = mem_data_i;

    // First asserted request at or after the pointer, wrapping downward to 0.
    always_comb begin : p_rr_search
        logic              v_found;
        logic [c_ID_W:0]   v_sum;
        v_found = 1'b0;
        v_sum   = '0;
        w_rr_id = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
            if (v_sum >= (c_ID_W + 1)'(NUM_REQUESTERS)) begin
                v_sum = v_sum - (c_ID_W + 1)'(NUM_REQUESTERS);
            end
            if (!v_found && req_valid_i[v_sum[c_ID_W-1:0]]) begin
                v_found = 1'b1;
                w_rr_id = v_sum[c_ID_W-1:0];
            end
        end
    end

    // The full check uses only the registered count, so a response never
    // opens a slot for a request in the same cycle.
    assign w_winner  = r_locked ? r_lock_id : w_rr_id;
    assign mem_req_o = rst_ni && (r_locked || (|req_valid_i)) && !w_full;
    assign w_hs      = mem_req_o && mem_ready_i;
    assign w_pop     = rst_ni && mem_valid_i && !w_empty;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        mem_addr_o  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (w_winner == c_ID_W'(i)) begin
                req_ready_o[i] = w_hs;
                mem_addr_o     = req_addr_i[i*CACHELINE_ADDR_WIDTH +: CACHELINE_ADDR_WIDTH];
            end
            if (w_head == c_ID_W'(i)) begin
                rsp_valid_o[i] = w_pop;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr  <= '0;
            r_locked  <= 1'b0;
            r_lock_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_hs) begin
                r_locked <= 1'b0;
                r_rr_ptr <= (w_winner == c_ID_W'(NUM_REQUESTERS - 1)) ? '0 : w_winner + 1'b1;
                r_wr_ptr <= f_inc_ptr(r_wr_ptr);
            end else if (mem_req_o) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_winner;
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc_ptr(r_rd_ptr);
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_fifo[r_wr_ptr] <= w_winner;
        end
    end

    logic                            r_hold_prev;
    logic [CACHELINE_ADDR_WIDTH-1:0] r_addr_prev;

    always_ff @(posedge clk_i) begin
        r_hold_prev <= rst_ni && mem_req_o && !mem_ready_i;
        r_addr_prev <= mem_addr_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(rsp_valid_o));
            assert (outstanding_o <= c_CNT_W'(MAX_OUTSTANDING));
            if (r_hold_prev) begin
                assert (mem_addr_o == r_addr_prev);
            end
            assert (!(mem_valid_i && w_empty))
                else $warning("icache_mem_arbiter: memory response with no request in flight dropped");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_mem_arbiter.sv
`default_nettype none
// Testbench for icache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_icache_mem_arbiter;

    localparam int N    = 4;
    localparam int AW   = 6;
    localparam int LW   = 32 << 2;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    rsp_valid_o;
    logic [LW-1:0]   rsp_data_o;
    logic            mem_req_o;
    logic            mem_ready;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_valid;
    logic [LW-1:0]   mem_data;
    logic [2:0]      outstanding_o;

    int n_checks;
    int n_fail;

    // Reference model: round-robin pointer, locked requester (-1 = none),
    // and the queue of requester IDs awaiting a response.
    int m_ptr;
    int m_lock;
    int m_q[$];

    always #5 clk = ~clk;

    icache_mem_arbiter #(
        .NUM_REQUESTERS      (N),
        .CACHELINE_ADDR_WIDTH(AW),
        .CACHELINE_IDX_BITS  (2),
        .ENC_INST_WIDTH      (32),
        .MAX_OUTSTANDING     (MAXO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .mem_req_o    (mem_req_o),
        .mem_ready_i  (mem_ready),
        .mem_addr_o   (mem_addr_o),
        .mem_valid_i  (mem_valid),
        .mem_data_i   (mem_data),
        .outstanding_o(outstanding_o)
    );

    function automatic int m_winner();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic tick();
        int w;
        bit req, hs, pop;
        w   = m_winner();
        req = rst_n && (m_lock >= 0 || req_valid != 0) && (m_q.size() < MAXO);
        hs  = req && mem_ready;
        pop = rst_n && mem_valid && (m_q.size() > 0);
        if (!rst_n) begin
            m_q.delete();
            m_ptr  = 0;
            m_lock = -1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(w);
                m_ptr  = (w + 1) % N;
                m_lock = -1;
            end else if (req) begin
                m_lock = w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        tick();
        tick();
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
        n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [LW-1:0] d;
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 6'h15;
        mem_ready = 1'b1;
        #1;
        n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL single_mem_req: got %b want 1", mem_req_o); end
        n_checks++; if (mem_addr_o !== 6'h15) begin n_fail++; $display("FAIL single_addr: got %h want 15", mem_addr_o); end
        n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready_o); end
        tick();
        req_valid = '0;
        tick();
        tick();
        d = {$urandom, $urandom, $urandom, $urandom};
        mem_data  = d;
        mem_valid = 1'b1;
        #1;
        n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d want 1", outstanding_o); end
        n_checks++; if (rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid_o); end
        n_checks++; if (rsp_data_o !== d) begin n_fail++; $display("FAIL single_rsp_data: got %h want %h", rsp_data_o, d); end
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL single_drained: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(6'h10 + i);
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        for (int g = 0; g <= 4; g++) begin
            mem_valid = (g >= 1);
            #1;
            exp = 4'b0001 << (g % 4);
            n_checks++; if (req_ready_o !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready_o, exp); end
            n_checks++; if (mem_addr_o !== AW'(6'h10 + g % 4)) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", g, mem_addr_o, 6'h10 + g % 4); end
            if (g >= 1) begin
                exp = 4'b0001 << (g - 1);
                n_checks++; if (rsp_valid_o !== exp) begin n_fail++; $display("FAIL rr_rsp%0d: got %b want %b", g, rsp_valid_o, exp); end
            end
            tick();
        end
        req_valid = '0;
        mem_valid = 1'b1;
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL rr_last_rsp: got %b want 0001", rsp_valid_o); end
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rr_drained: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_addr[1*AW +: AW] = 6'h0A;
        req_addr[0*AW +: AW] = 6'h33;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) req_valid = 4'b0011;
            #1;
            n_checks++; if (mem_addr_o !== 6'h0A || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got req %b addr %h want req 1 addr 0a", c, mem_req_o, mem_addr_o); end
            n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_noready%0d: got %b want 0000", c, req_ready_o); end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++; if (req_ready_o !== 4'b0010 || mem_addr_o !== 6'h0A) begin n_fail++; $display("FAIL bp_grant1: got ready %b addr %h want 0010 0a", req_ready_o, mem_addr_o); end
        tick();
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready_o !== 4'b0001 || mem_addr_o !== 6'h33) begin n_fail++; $display("FAIL bp_grant0: got ready %b addr %h want 0001 33", req_ready_o, mem_addr_o); end
        tick();
        req_valid = '0;
        mem_valid = 1'b1;
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp1: got %b want 0010", rsp_valid_o); end
        tick();
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL bp_rsp0: got %b want 0001", rsp_valid_o); end
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [N-1:0] exp;
        do_reset();
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        for (int g = 0; g < MAXO; g++) tick();
        #1;
        n_checks++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", outstanding_o); end
        n_checks++; if (mem_req_o !== 1'b0 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL full_blocked: got req %b ready %b want 0 0000", mem_req_o, req_ready_o); end
        mem_valid = 1'b1;
        #1;
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b want 0", mem_req_o); end
        n_checks++; if (rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL full_rsp: got %b want 0001", rsp_valid_o); end
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL full_popped: got %0d want 3", outstanding_o); end
        n_checks++; if (mem_req_o !== 1'b1 || req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_regrant: got req %b ready %b want 1 0001", mem_req_o, req_ready_o); end
        tick();
        req_valid = '0;
        mem_valid = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            #1;
            exp = 4'b0001 << ((k + 1) % 4);
            n_checks++; if (rsp_valid_o !== exp) begin n_fail++; $display("FAIL full_drain%0d: got %b want %b", k, rsp_valid_o, exp); end
            tick();
        end
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_push_pop();
        do_reset();
        mem_ready = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0010;
        mem_valid = 1'b1;
        #1;
        n_checks++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL pp_before: got %0d want 2", outstanding_o); end
        n_checks++; if (req_ready_o !== 4'b0010 || rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL pp_same_cycle: got ready %b rsp %b want 0010 0100", req_ready_o, rsp_valid_o); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL pp_after: got %0d want 2", outstanding_o); end
        n_checks++; if (rsp_valid_o !== 4'b1000) begin n_fail++; $display("FAIL pp_rsp3: got %b want 1000", rsp_valid_o); end
        tick();
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL pp_rsp1: got %b want 0010", rsp_valid_o); end
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        for (int g = 0; g < 3; g++) tick();
        req_valid = '0;
        #1;
        n_checks++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL mid_before: got %0d want 3", outstanding_o); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL mid_cleared: got %0d want 0", outstanding_o); end
        mem_valid = 1'b1;
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_spurious: got %b want 0000", rsp_valid_o); end
        tick();
        mem_valid = 1'b0;
        req_valid = 4'b1001;
        #1;
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", req_ready_o); end
        tick();
        req_valid = '0;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL mid_drained: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_random();
        logic [N-1:0] e_ready, e_rsp;
        logic         e_req;
        int           w;
        do_reset();
        e_ready = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || e_ready[i]) begin
                    req_valid[i] = ($urandom_range(2, 0) == 0);
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            mem_ready = ($urandom_range(3, 0) != 0);
            mem_valid = (m_q.size() > 0) && ($urandom_range(1, 0) == 1);
            mem_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            w       = m_winner();
            e_req   = (m_lock >= 0 || req_valid != 0) && (m_q.size() < MAXO);
            e_ready = '0;
            if (e_req && mem_ready) e_ready[w] = 1'b1;
            e_rsp = '0;
            if (mem_valid && m_q.size() > 0) e_rsp[m_q[0]] = 1'b1;
            n_checks++; if (mem_req_o !== e_req) begin n_fail++; $display("FAIL rnd_mem_req cyc %0d: got %b want %b", cyc, mem_req_o, e_req); end
            n_checks++; if (req_ready_o !== e_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, req_ready_o, e_ready); end
            n_checks++; if (rsp_valid_o !== e_rsp) begin n_fail++; $display("FAIL rnd_rsp cyc %0d: got %b want %b", cyc, rsp_valid_o, e_rsp); end
            n_checks++; if (outstanding_o !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_outstanding cyc %0d: got %0d want %0d", cyc, outstanding_o, m_q.size()); end
            n_checks++; if (rsp_data_o !== mem_data) begin n_fail++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, rsp_data_o, mem_data); end
            if (e_req) begin
                n_checks++; if (mem_addr_o !== req_addr[w*AW +: AW]) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, mem_addr_o, req_addr[w*AW +: AW]); end
            end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < MAXO && m_q.size() > 0; k++) begin
            mem_valid = 1'b1;
            tick();
        end
        mem_valid = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rnd_drained: got %0d want 0", outstanding_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ptr    = 0;
        m_lock   = -1;
        rst_n    = 1'b0;
        req_addr = '0;
        mem_data = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/icache_mem_arbiter.md
Name: icache_mem_arbiter

Overview:
- Shares one instruction-memory port between NumRequesters instruction caches, one per compute unit.
- Arbitrates cacheline requests round-robin and forwards the winner to memory.
- Records each granted requester ID in an in-order routing FIFO, then steers each memory response back to the requester at the FIFO head.
- Sits between the per-unit instruction caches and the shared instruction memory. Memory responses have no ready signal and return strictly in request order.

Parameters:
NumRequesters, 4, number of instruction caches sharing the port (>=2)
CachelineAddrWidth, 6, width of a cacheline address (PcWidth - CachelineIdxBits)
CachelineIdxBits, 2, log2 of instructions per cacheline
EncInstWidth, 32, width of one encoded instruction
MaxOutstanding, 4, depth of routing FIFO = max in-flight memory requests (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NumRequesters  per-requester memory request valid
req_ready_o  out  NumRequesters  per-requester request accepted
req_addr_i  in  NumRequesters*CachelineAddrWidth  per-requester cacheline address, requester i at slice i
rsp_valid_o  out  NumRequesters  per-requester response valid, one-hot or zero
rsp_data_o  out  EncInstWidth<<CachelineIdxBits  response cacheline, broadcast to all requesters
mem_req_o  out  1  request valid to memory
mem_ready_i  in  1  memory accepts request
mem_addr_o  out  CachelineAddrWidth  cacheline address to memory
mem_valid_i  in  1  memory response valid (no ready)
mem_data_i  in  EncInstWidth<<CachelineIdxBits  memory response cacheline
outstanding_o  out  $clog2(MaxOutstanding+1)  current in-flight request count

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is synchronous, active-low.
- Reset values:
  - Round-robin pointer = 0, lock cleared, routing FIFO empty, outstanding_o = 0.
  - mem_req_o = 0, req_ready_o = 0, rsp_valid_o = 0.
- Requester stream rule: req_valid_i[i] and req_addr_i[i] are held until req_ready_o[i]. The arbiter relies on this.
- Arbitration:
  - The winner is the first asserted req_valid_i at or after the pointer, searching upward with wrap from NumRequesters-1 to 0.
  - mem_req_o = (any req_valid_i) && !fifo_full.
  - mem_addr_o = req_addr_i[winner].
- Grant lock:
  - If mem_req_o=1 and mem_ready_i=0, the winner is registered and locked.
  - While locked, the locked ID drives mem_addr_o and mem_req_o regardless of other requesters. The address is therefore stable until the handshake (AXI-stream style valid/ready).
  - The lock clears on handshake.
- Handshake:
  - Occurs when mem_req_o && mem_ready_i.
  - req_ready_o[winner] = mem_ready_i && mem_req_o; all other req_ready_o are 0.
  - On handshake: push winner ID into the FIFO, set pointer = (winner+1) mod NumRequesters.
  - Latency from request to memory is 0 cycles (combinational path when unlocked).
- Full FIFO:
  - When the FIFO is full, mem_req_o = 0 and no grant is made.
  - A pop in the same cycle does NOT enable a push. There is no combinational path from mem_valid_i to mem_req_o or req_ready_o.
  - A pending lock persists across the full period.
- Response routing:
  - rsp_valid_o[head] = mem_valid_i && !fifo_empty, with 0-cycle latency.
  - rsp_data_o = mem_data_i unconditionally.
  - mem_valid_i pops the FIFO head.
- Simultaneous push and pop (FIFO not full): both occur; the count is unchanged. A request issued in the same cycle as a response is never routed that response, because the pop uses the old head.
- Spurious response: mem_valid_i with the FIFO empty is dropped. rsp_valid_o stays 0, and a simulation assertion fires.
- outstanding_o: registered FIFO occupancy, range 0..MaxOutstanding.
- Reset mid-operation: FIFO, lock and pointer are cleared. Responses to pre-reset requests that arrive later hit an empty FIFO and are dropped.
- Assertions:
  - rsp_valid_o is one-hot-or-zero.
  - mem_addr_o is stable while mem_req_o && !mem_ready_i.
  - outstanding_o <= MaxOutstanding.

Test Plan:
- Single requester: req 2 valid, addr 0x15, mem_ready_i=1 -> same cycle mem_req_o=1, mem_addr_o=0x15, req_ready_o=4'b0100. A response 3 cycles later gives rsp_valid_o=4'b0100 and rsp_data_o=mem_data_i.
- Round-robin: all 4 requesters valid continuously, mem_ready_i=1, pointer 0 -> grants in order 0,1,2,3,0. The FIFO records the same order, and four in-order responses assert rsp_valid_o bits 0,1,2,3.
- Backpressure lock: req 1 valid addr 0x0A, mem_ready_i=0 for 3 cycles; req 0 asserts in cycle 2 -> mem_addr_o holds 0x0A for all cycles. Req 1 is granted when ready rises; req 0 is granted next cycle.
- FIFO full: MaxOutstanding=4 grants without responses -> outstanding_o=4, mem_req_o=0 with requests pending. A response in cycle N pops (outstanding_o=3 in N+1); the next grant occurs no earlier than N+1.
- Simultaneous push/pop: outstanding_o=2, handshake and mem_valid_i in the same cycle -> outstanding_o stays 2. The response routes to the old head; the new ID is appended at the tail.
- Reset mid-operation: 3 outstanding, rst_ni=0 for 1 cycle -> outstanding_o=0, pointer=0. A subsequent mem_valid_i yields rsp_valid_o=0 and the spurious-response assertion fires.
